// File: rtl/perf_pkg.sv
// Shared constants for the mp_perf performance-counter bank: address decode,
// register offsets inside the window, CTRL bit positions and bus FSM states.
package perf_pkg;

    // Window decode: the upper 24 address bits select the bank.
    localparam logic [31:0] DEC_MASK   = 32'hFFFF_FF00;

    // Register offsets relative to the window base.
    localparam logic [7:0]  OFF_CTRL   = 8'h00;
    localparam logic [7:0]  OFF_ENA    = 8'h04;
    localparam logic [7:0]  OFF_OVF    = 8'h08;
    localparam logic [7:0]  OFF_OVF_IE = 8'h0C;
    localparam logic [7:0]  OFF_SEL    = 8'h40;   // 0x40 + 4*i
    localparam logic [7:0]  OFF_CNT    = 8'h80;   // 0x80 + 8*i (low), +4 (high)

    // CTRL bit positions.
    localparam int CTRL_GEN  = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_SNAP = 2;

    // Bus controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mp_perf_cnt.sv
// One performance counter: event select mux, halfword load port, count
// enable and wrap detection. Priority is clear > load > increment, so a
// load or clear in the same cycle as an event silently drops that event.
module mp_perf_cnt #(
    parameter int CNT_W = 48,
    parameter int EVT_W = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [EVT_W-1:0] evt,
    input  logic [SEL_W-1:0] sel,
    input  logic             count_en,
    input  logic             clr,
    input  logic [CNT_W-1:0] load_mask,
    input  logic [CNT_W-1:0] load_data,
    output logic [CNT_W-1:0] value,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             evt_hit;
    logic             load;
    logic             inc;

    // Event mux, priority resolution and next-value computation.
    always_comb begin
        evt_hit = 1'b0;
        // Select values beyond the last event input count nothing.
        if ({{(32-SEL_W){1'b0}}, sel} < 32'(EVT_W)) begin
            evt_hit = evt[sel];
        end
        load     = |load_mask;
        inc      = count_en && evt_hit && !load && !clr;
        wrap     = inc && (&cnt_reg);
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (load) begin
            cnt_next = (cnt_reg & ~load_mask) | (load_data & load_mask);
        end else if (inc) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign value = cnt_reg;

endmodule

// File: rtl/mp_perf.sv
// mp_perf: parametrised performance-counter bank on the mgmt bus.
// Holds the bus controller FSM, CTRL/ENA/OVF/OVF_IE/SEL registers, the read
// mux with the hi_hold read-consistency latch, and the registered interrupt.
// Optional feature macro: PERF_SNAPSHOT_EN -- adds shadow registers loaded by
// CTRL.SNAP; counter reads then return the shadow copy instead of live values.
module mp_perf #(
    parameter int          NUM_CNT = 8,
    parameter int          CNT_W   = 48,
    parameter int          EVT_W   = 16,
    parameter logic [31:0] BASE    = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [EVT_W-1:0] evt,
    input  logic             freeze,
    input  logic             mgmt_req,
    input  logic [31:0]      mgmt_adr,
    input  logic             mgmt_rwn,
    input  logic [1:0]       mgmt_wen,
    input  logic [31:0]      mgmt_txd,
    output logic             mgmt_ack,
    output logic             mgmt_rxe,
    output logic [31:0]      mgmt_rxd,
    output logic             perf_irq
);
    import perf_pkg::*;

    localparam int SEL_W = $clog2(EVT_W);
    localparam int HI_W  = CNT_W - 32;

    state_t state_reg, state_next;

    logic [31:0]              adr_reg;
    logic [31:0]              txd_reg;
    logic                     rwn_reg;
    logic [1:0]               wen_reg;

    logic                     gen_reg;
    logic [NUM_CNT-1:0]       ena_reg;
    logic [NUM_CNT-1:0]       ovf_reg;
    logic [NUM_CNT-1:0]       ovf_ie_reg;
    logic [HI_W-1:0]          hi_hold_reg;
    logic                     ack_reg;
    logic                     rxe_reg;
    logic [31:0]              rxd_reg;
    logic                     irq_reg;

    logic [NUM_CNT*CNT_W-1:0] cnt_flat;
    logic [NUM_CNT*CNT_W-1:0] rd_src;
    logic [NUM_CNT*SEL_W-1:0] sel_flat;
    logic [NUM_CNT-1:0]       wrap;
    logic [NUM_CNT-1:0]       ovf_clr;

    logic [7:0]               off;
    logic                     in_win;
    logic                     wr_go;
    logic                     rd_go;
    logic                     wr_lo;
    logic                     aligned;
    logic                     sel_hit;
    logic                     cnt_hit;
    logic [3:0]               sel_idx;
    logic [2:0]               cnt_idx;
    logic                     cnt_hi;
    logic                     clr_pulse;
    logic                     count_en;
    logic [31:0]              wmask;
    logic [CNT_W-1:0]         lo_mask;
    logic [CNT_W-1:0]         hi_mask;
    logic [CNT_W-1:0]         load_word;
    logic [31:0]              rdata;
    logic                     hold_load;
    logic [HI_W-1:0]          hold_val;

    // Bus FSM state register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus FSM next state: one EXEC cycle, then wait for the request to drop.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (mgmt_req)  state_next = S_EXEC;
            S_EXEC:                 state_next = S_DONE;
            S_DONE:  if (!mgmt_req) state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // Capture the request fields when a transaction is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_reg <= '0;
            txd_reg <= '0;
            rwn_reg <= 1'b0;
            wen_reg <= '0;
        end else if (state_reg == S_IDLE && mgmt_req) begin
            adr_reg <= mgmt_adr;
            txd_reg <= mgmt_txd;
            rwn_reg <= mgmt_rwn;
            wen_reg <= mgmt_wen;
        end
    end

    // Address decode of the captured request.
    assign off       = adr_reg[7:0];
    assign in_win    = (adr_reg & DEC_MASK) == BASE;
    assign wr_go     = (state_reg == S_EXEC) && in_win && !rwn_reg;
    assign rd_go     = (state_reg == S_EXEC) && in_win && rwn_reg;
    assign wr_lo     = wr_go && wen_reg[0];
    assign aligned   = off[1:0] == 2'b00;
    assign sel_hit   = aligned && (off[7:6] == OFF_SEL[7:6]);
    assign cnt_hit   = aligned && (off[7:6] == OFF_CNT[7:6]);
    assign sel_idx   = off[5:2];
    assign cnt_idx   = off[5:3];
    assign cnt_hi    = off[2];
    assign clr_pulse = wr_lo && (off == OFF_CTRL) && txd_reg[CTRL_CLR];
    // A CLR-write cycle also blocks counting.
    assign count_en  = gen_reg && !freeze && !clr_pulse;

    // Halfword load masks for the low and high counter words.
    assign wmask     = {{16{wen_reg[1]}}, {16{wen_reg[0]}}};
    assign lo_mask   = {{HI_W{1'b0}}, wmask};
    assign hi_mask   = {wmask[HI_W-1:0], 32'h0};
    assign load_word = {txd_reg[HI_W-1:0], txd_reg};
    assign ovf_clr   = (wr_lo && off == OFF_OVF) ? txd_reg[NUM_CNT-1:0] : '0;

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        logic [SEL_W-1:0] sel_reg;
        logic             cnt_sel;
        logic [CNT_W-1:0] load_mask;

        // Event-select register; counter i defaults to event i mod EVT_W.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sel_reg <= SEL_W'(gi % EVT_W);
            end else if (wr_lo && sel_hit && sel_idx == 4'(gi)) begin
                sel_reg <= txd_reg[SEL_W-1:0];
            end
        end

        assign cnt_sel   = wr_go && cnt_hit && (cnt_idx == 3'(gi));
        assign load_mask = !cnt_sel ? '0 : (cnt_hi ? hi_mask : lo_mask);
        assign sel_flat[gi*SEL_W +: SEL_W] = sel_reg;

        mp_perf_cnt #(
            .CNT_W(CNT_W),
            .EVT_W(EVT_W),
            .SEL_W(SEL_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .evt       (evt),
            .sel       (sel_reg),
            .count_en  (count_en && ena_reg[gi]),
            .clr       (clr_pulse),
            .load_mask (load_mask),
            .load_data (load_word),
            .value     (cnt_flat[gi*CNT_W +: CNT_W]),
            .wrap      (wrap[gi])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    logic                     snap_pulse;
    logic [NUM_CNT*CNT_W-1:0] shadow_reg;

    assign snap_pulse = wr_lo && (off == OFF_CTRL) && txd_reg[CTRL_SNAP];

    // Shadow copy of every counter, taken on a SNAP write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg <= '0;
        end else if (snap_pulse) begin
            shadow_reg <= cnt_flat;
        end
    end

    assign rd_src = shadow_reg;
`else
    assign rd_src = cnt_flat;
`endif

    // Control and status registers; a wrap beats a same-cycle W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_reg    <= 1'b0;
            ena_reg    <= '0;
            ovf_reg    <= '0;
            ovf_ie_reg <= '0;
        end else begin
            if (wr_lo && off == OFF_CTRL)   gen_reg    <= txd_reg[CTRL_GEN];
            if (wr_lo && off == OFF_ENA)    ena_reg    <= txd_reg[NUM_CNT-1:0];
            if (wr_lo && off == OFF_OVF_IE) ovf_ie_reg <= txd_reg[NUM_CNT-1:0];
            ovf_reg <= (ovf_reg & ~ovf_clr) | wrap;
        end
    end

    // Read mux; a counter low-word read also prepares the hi_hold latch.
    always_comb begin
        rdata     = '0;
        hold_load = 1'b0;
        hold_val  = hi_hold_reg;
        if (off == OFF_CTRL)   rdata[CTRL_GEN]    = gen_reg;
        if (off == OFF_ENA)    rdata[NUM_CNT-1:0] = ena_reg;
        if (off == OFF_OVF)    rdata[NUM_CNT-1:0] = ovf_reg;
        if (off == OFF_OVF_IE) rdata[NUM_CNT-1:0] = ovf_ie_reg;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (sel_hit && sel_idx == 4'(i)) begin
                rdata[SEL_W-1:0] = sel_flat[i*SEL_W +: SEL_W];
            end
            if (cnt_hit && cnt_idx == 3'(i)) begin
                if (!cnt_hi) begin
                    rdata     = rd_src[i*CNT_W +: 32];
                    hold_load = 1'b1;
                    hold_val  = cnt_flat[i*CNT_W+32 +: HI_W];
                end else begin
`ifdef PERF_SNAPSHOT_EN
                    rdata = 32'(rd_src[i*CNT_W+32 +: HI_W]);
`else
                    rdata = 32'(hi_hold_reg);
`endif
                end
            end
        end
    end

    // hi_hold: upper counter bits frozen at the last low-word read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_hold_reg <= '0;
        end else if (rd_go && hold_load) begin
            hi_hold_reg <= hold_val;
        end
    end

    // Bus response registers: one-cycle ack, read data valid only with rxe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg <= 1'b0;
            rxe_reg <= 1'b0;
            rxd_reg <= '0;
        end else begin
            ack_reg <= (state_reg == S_EXEC) && in_win;
            rxe_reg <= rd_go;
            rxd_reg <= rd_go ? rdata : 32'h0;
        end
    end

    // Interrupt follows enabled overflow status one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(ovf_reg & ovf_ie_reg);
        end
    end

    assign mgmt_ack = ack_reg;
    assign mgmt_rxe = rxe_reg;
    assign mgmt_rxd = rxd_reg;
    assign perf_irq = irq_reg;

endmodule
